// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module   : icache
// Purpose  : Direct-mapped instruction cache feeding the IFQ. Returns a
//            128-bit line of 4 instructions per fetch. Misses are refilled
//            word-serially from instruction memory. Abort from the IFQ
//            drops any pending response.
// Revision : 1.0  initial release
// ============================================================================
module icache #(
  parameter int IDX_BITS = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  Pc_in,
  input  logic         Rd_en,
  input  logic         Abort,
  output logic [127:0] Dout,
  output logic         Dout_valid,
  output logic         Mem_rd_en,
  output logic [31:0]  Mem_addr,
  input  logic [31:0]  Mem_data,
  input  logic         Mem_data_valid
);

  localparam int TAG_BITS = 28 - IDX_BITS;
  localparam int LINES    = 1 << IDX_BITS;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RESP  = 3'd1;
  localparam logic [2:0] MREQ  = 3'd2;
  localparam logic [2:0] MWAIT = 3'd3;
  localparam logic [2:0] FILL  = 3'd4;

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic [27:0]         req_addr;
  logic [1:0]          beat;
  logic                cancel;
  logic [127:0]        refill;
  logic [LINES-1:0]    valid_bits;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [127:0]        data_mem [LINES];

  logic [IDX_BITS-1:0] lkp_idx;
  logic [IDX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0] lkp_tag;
  logic [TAG_BITS-1:0] req_tag;
  logic                hit;
  logic                accept;
  logic                unused_low;

  assign lkp_idx    = Pc_in[4 +: IDX_BITS];
  assign lkp_tag    = Pc_in[31 -: TAG_BITS];
  assign req_idx    = req_addr[IDX_BITS-1:0];
  assign req_tag    = req_addr[27 -: TAG_BITS];
  assign hit        = valid_bits[lkp_idx] && (tag_mem[lkp_idx] == lkp_tag);
  // A request is only taken in IDLE; an Abort in the same cycle kills it.
  assign accept     = (state == IDLE) && Rd_en && !Abort;
  // Offset bits inside the line are irrelevant to a line-aligned fetch.
  assign unused_low = ^Pc_in[3:0];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = hit ? RESP : MREQ;
      RESP:    state_nxt = IDLE;
      MREQ:    state_nxt = MWAIT;
      MWAIT:   if (Mem_data_valid && (beat == 2'd3)) state_nxt = FILL;
      FILL:    state_nxt = (cancel || Abort) ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: response valid is gated by a same-cycle Abort
  always_comb begin
    Dout_valid = (state == RESP) && !Abort;
    Mem_rd_en  = (state == MREQ);
  end

  // Request capture, refill assembly, response line and cancel tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_addr <= '0;
      Mem_addr <= '0;
      beat     <= '0;
      cancel   <= 1'b0;
      refill   <= '0;
      Dout     <= '0;
    end else begin
      if (accept) begin
        req_addr <= Pc_in[31:4];
        if (hit) Dout     <= data_mem[lkp_idx];
        else     Mem_addr <= {Pc_in[31:4], 4'b0000};
      end
      if (state == MREQ) beat <= 2'd0;
      if ((state == MWAIT) && Mem_data_valid) begin
        case (beat)
          2'd0: refill[127:96] <= Mem_data;
          2'd1: refill[95:64]  <= Mem_data;
          2'd2: refill[63:32]  <= Mem_data;
          2'd3: refill[31:0]   <= Mem_data;
        endcase
        beat <= beat + 2'd1;
      end
      if (state == FILL) Dout <= refill;
      // The flag lives for one miss only; entering IDLE always clears it.
      if (state_nxt == IDLE)
        cancel <= 1'b0;
      else if (Abort && ((state == MREQ) || (state == MWAIT) || (state == FILL)))
        cancel <= 1'b1;
    end
  end

  // Valid bits: cleared by reset, set when a refill installs a line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             valid_bits <= '0;
    else if (state == FILL) valid_bits[req_idx] <= 1'b1;
  end

  // Tag and data storage, not reset; guarded by the valid bits
  always_ff @(posedge clk) begin
    if (state == FILL) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= refill;
    end
  end

endmodule
`default_nettype wire
